filter_bank: RTL and testbench



---
 rtl/filter_bank_if.sv | 25 ++
 rtl/filter_bank.sv | 138 +++++++++++++
 tb/tb_filter_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_bank_if.sv
// filter_bank_if: sample/coefficient inputs and channel outputs of the filter bank.
// The master side supplies samples and coefficients; the slave is the filter bank.

interface filter_bank_if #(parameter int N_CH = 4);
  logic               valid_in;
  logic signed [23:0] sample_in;
  logic signed [31:0] b0 [N_CH];
  logic signed [31:0] b1 [N_CH];
  logic signed [31:0] b2 [N_CH];
  logic signed [31:0] a1 [N_CH];
  logic signed [31:0] a2 [N_CH];
  logic signed [31:0] channels_out [N_CH];
  logic               valid_out;
  logic               busy;

  modport master (
    output valid_in, sample_in, b0, b1, b2, a1, a2,
    input  channels_out, valid_out, busy
  );

  modport slave (
    input  valid_in, sample_in, b0, b1, b2, a1, a2,
    output channels_out, valid_out, busy
  );
endinterface

// File: rtl/filter_bank.sv
// filter_bank: analysis filter bank for the vocoder channel path.
// Splits one audio sample into N_CH bandpass channel samples. A single shared
// multiplier evaluates N_CH Direct Form I biquads one after another, and all
// channel results are published together with a one-cycle valid pulse.

package filter_bank_pkg;
  localparam int N_FILTERS = 4;
endpackage

module filter_bank #(
  parameter int N_CH       = filter_bank_pkg::N_FILTERS,
  parameter int COEFF_FRAC = 30
) (
  input  logic          clk_in,
  input  logic          rst_in,
  filter_bank_if.slave  bus
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  typedef enum logic [1:0] {IDLE, MAC, UPDATE, DONE} state_t;

  state_t             state_q;
  logic [2:0]         term_q;
  logic [CW-1:0]      ch_q;
  logic signed [63:0] acc_q;
  logic signed [31:0] x0_q, x1_q, x2_q;
  logic signed [31:0] y1_q [N_CH];
  logic signed [31:0] y2_q [N_CH];
  logic signed [31:0] res_q [N_CH];
  logic signed [31:0] chanOut_q [N_CH];
  logic               validOut_q;
  logic               busy_q;

  logic signed [31:0] mulA_d, mulB_d;
  logic signed [63:0] mulAExt_d, mulBExt_d;
  logic signed [63:0] prod_d;
  logic signed [63:0] shifted_d;
  logic signed [31:0] yNext_d;

  // Pick the coefficient/data pair for the current term of the current channel.
  always_comb begin
    mulA_d = '0;
    mulB_d = '0;
    case (term_q)
      3'd0: begin mulA_d = bus.b0[ch_q]; mulB_d = x0_q;       end
      3'd1: begin mulA_d = bus.b1[ch_q]; mulB_d = x1_q;       end
      3'd2: begin mulA_d = bus.b2[ch_q]; mulB_d = x2_q;       end
      3'd3: begin mulA_d = bus.a1[ch_q]; mulB_d = y1_q[ch_q]; end
      3'd4: begin mulA_d = bus.a2[ch_q]; mulB_d = y2_q[ch_q]; end
      default: begin mulA_d = '0; mulB_d = '0; end
    endcase
  end

  // Shared 32x32 signed multiplier; feedback terms are subtracted in the accumulator
  // rather than negated here so a1/a2 = -2^31 cannot overflow.
  assign mulAExt_d = {{32{mulA_d[31]}}, mulA_d};
  assign mulBExt_d = {{32{mulB_d[31]}}, mulB_d};
  assign prod_d    = mulAExt_d * mulBExt_d;

  // Floor-shift the accumulator back to Q0 and clamp to 32 bits.
  always_comb begin
    shifted_d = acc_q >>> COEFF_FRAC;
    if (shifted_d > SAT_MAX)      yNext_d = 32'sh7FFF_FFFF;
    else if (shifted_d < SAT_MIN) yNext_d = 32'sh8000_0000;
    else                          yNext_d = shifted_d[31:0];
  end

  // Sequencer: accept a sample, run five MAC terms per channel, write back, publish.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      term_q     <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      validOut_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        y1_q[k]      <= '0;
        y2_q[k]      <= '0;
        res_q[k]     <= '0;
        chanOut_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          validOut_q <= 1'b0;
          if (bus.valid_in) begin
            x0_q    <= {{8{bus.sample_in[23]}}, bus.sample_in};
            ch_q    <= '0;
            term_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (term_q >= 3'd3) acc_q <= acc_q - prod_d;
          else                acc_q <= acc_q + prod_d;
          if (term_q == 3'd4) state_q <= UPDATE;
          else                term_q  <= term_q + 3'd1;
        end
        UPDATE: begin
          res_q[ch_q] <= yNext_d;
          y2_q[ch_q]  <= y1_q[ch_q];
          y1_q[ch_q]  <= yNext_d;
          acc_q       <= '0;
          term_q      <= '0;
          if (ch_q == CW'(N_CH - 1)) begin
            state_q <= DONE;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= MAC;
          end
        end
        DONE: begin
          chanOut_q  <= res_q;
          x2_q       <= x1_q;
          x1_q       <= x0_q;
          validOut_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.channels_out = chanOut_q;
  assign bus.valid_out    = validOut_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_filter_bank.sv
// tb_filter_bank: scoreboard bench for filter_bank with four channels.
// A per-sample reference model pushes expected channel values when a sample is
// driven; a monitor pops and compares them whenever valid_out pulses.

module tb_filter_bank;

  localparam int NCH = 4;
  localparam int ONE = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  int     expQ [$];
  longint mx1, mx2;
  longint my1 [NCH];
  longint my2 [NCH];

  always #5 clk = ~clk;

  filter_bank_if #(.N_CH(NCH)) bus ();

  filter_bank #(.N_CH(NCH), .COEFF_FRAC(30)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int sat32(input longint v);
    if (v > 64'sd2147483647) return 32'sh7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'sh8000_0000;
    return int'(v);
  endfunction

  task automatic modelClear();
    mx1 = 0;
    mx2 = 0;
    for (int k = 0; k < NCH; k++) begin
      my1[k] = 0;
      my2[k] = 0;
    end
  endtask

  // Reference: the biquad difference equation evaluated directly for every channel.
  task automatic modelPush(input logic signed [23:0] s);
    longint x0, acc;
    int     y;
    x0 = longint'(s);
    for (int k = 0; k < NCH; k++) begin
      acc = longint'(bus.b0[k]) * x0 + longint'(bus.b1[k]) * mx1
          + longint'(bus.b2[k]) * mx2 - longint'(bus.a1[k]) * my1[k]
          - longint'(bus.a2[k]) * my2[k];
      y = sat32(acc >>> 30);
      my2[k] = my1[k];
      my1[k] = y;
      expQ.push_back(y);
    end
    mx2 = mx1;
    mx1 = x0;
  endtask

  task automatic setCoeffs(input int b0v, input int b1v, input int b2v,
                           input int a1v, input int a2v);
    for (int k = 0; k < NCH; k++) begin
      bus.b0[k] = b0v;
      bus.b1[k] = b1v;
      bus.b2[k] = b2v;
      bus.a1[k] = a1v;
      bus.a2[k] = a2v;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    modelClear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one sample, optionally inject a dropped valid_in at edge dropEdge,
  // then time the response: valid_out must rise exactly 25 edges after acceptance.
  task automatic applyStimulus(input logic signed [23:0] s, input int dropEdge);
    int cycles;
    int busyLow;
    @(negedge clk);
    bus.sample_in = s;
    bus.valid_in  = 1'b1;
    modelPush(s);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    cycles  = 0;
    busyLow = (bus.busy === 1'b1) ? 0 : 1;
    while (bus.valid_out !== 1'b1 && cycles < 200) begin
      if (dropEdge > 0 && cycles == dropEdge - 1) begin
        bus.sample_in = 24'sd5555;
        bus.valid_in  = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      cycles++;
      if (bus.valid_out !== 1'b1 && bus.busy !== 1'b1) busyLow++;
    end
    checkOutput("latency", cycles, 25);
    checkOutput("busyHeld", busyLow, 0);
    checkOutput("busyClear", bus.busy, 0);
  endtask

  // Scoreboard monitor: compare the published vector against the model.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid_out === 1'b1) begin
      if (expQ.size() < NCH) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        for (int k = 0; k < NCH; k++)
          checkOutput($sformatf("ch%0d", k), bus.channels_out[k], expQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.sample_in = '0;
    setCoeffs(0, 0, 0, 0, 0);
    modelClear();
    #22;
    checkOutput("rstValid", bus.valid_out, 0);
    checkOutput("rstBusy", bus.busy, 0);
    for (int k = 0; k < NCH; k++)
      checkOutput($sformatf("rstCh%0d", k), bus.channels_out[k], 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] passthrough");
    setCoeffs(ONE, 0, 0, 0, 0);
    applyStimulus(24'sd1000, 0);
    applyStimulus(-24'sd1000, 0);

    $display("[TB] per-channel gain");
    for (int k = 0; k < NCH; k++) bus.b0[k] = k * (ONE / 2);
    applyStimulus(24'sd1000, 0);

    $display("[TB] unit delay");
    doReset();
    setCoeffs(0, ONE, 0, 0, 0);
    applyStimulus(24'sd7, 0);
    applyStimulus(24'sd9, 0);

    $display("[TB] two-sample delay");
    doReset();
    setCoeffs(0, 0, ONE, 0, 0);
    applyStimulus(24'sd7, 0);
    applyStimulus(24'sd9, 0);
    applyStimulus(24'sd11, 0);

    $display("[TB] recursion");
    doReset();
    setCoeffs(ONE, 0, 0, -(ONE / 2), 0);
    applyStimulus(24'sd1024, 0);
    applyStimulus(24'sd0, 0);
    applyStimulus(24'sd0, 0);

    $display("[TB] floor shift");
    doReset();
    setCoeffs(ONE / 2, 0, 0, 0, 0);
    applyStimulus(-24'sd3, 0);

    $display("[TB] positive saturation");
    doReset();
    setCoeffs(ONE, 0, 0, 32'sh8000_0000, 0);
    for (int i = 0; i < 10; i++) applyStimulus(24'sd8388607, 0);

    $display("[TB] negative saturation");
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(-24'sd8388608, 0);

    $display("[TB] busy drop");
    doReset();
    setCoeffs(ONE, 0, 0, 0, 0);
    applyStimulus(24'sd1000, 3);
    repeat (30) @(posedge clk);
    applyStimulus(24'sd2000, 0);

    $display("[TB] reset mid-operation");
    setCoeffs(0, ONE, 0, 0, 0);
    @(negedge clk);
    bus.sample_in = 24'sd7;
    bus.valid_in  = 1'b1;
    modelPush(24'sd7);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstValid", bus.valid_out, 0);
    for (int k = 0; k < NCH; k++)
      checkOutput($sformatf("midRstCh%0d", k), bus.channels_out[k], 0);
    expQ.delete();
    modelClear();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    applyStimulus(24'sd9, 0);

    $display("[TB] random coefficients");
    doReset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NCH; k++) begin
        bus.b0[k] = int'($urandom_range(0, ONE)) - ONE / 2;
        bus.b1[k] = int'($urandom_range(0, ONE)) - ONE / 2;
        bus.b2[k] = int'($urandom_range(0, ONE)) - ONE / 2;
        bus.a1[k] = int'($urandom_range(0, ONE)) - ONE / 2;
        bus.a2[k] = int'($urandom_range(0, ONE / 2)) - ONE / 4;
      end
      applyStimulus(24'(int'($urandom_range(0, 16777215))), 0);
    end

    repeat (5) @(posedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
